// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data ports and memory port bundled for the shared-memory arbiter.
// The master modport is the arbiter's view. The slave modport is the core plus memory.
interface mem_port_arbiter_if #(
  parameter int size = 32
);
  logic            if_req;
  logic [size-1:0] if_addr;
  logic            if_flush;
  logic [size-1:0] if_instr;
  logic            if_valid;

  logic            d_req;
  logic            d_we;
  logic [size-1:0] d_addr;
  logic [size-1:0] d_wdata;
  logic [2:0]      d_width;
  logic [size-1:0] d_rdata;
  logic            d_done;

  logic            mem_req;
  logic            mem_we;
  logic [size-1:0] mem_addr;
  logic [size-1:0] mem_wdata;
  logic [2:0]      mem_width;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [size-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_instr, if_valid,
    input  d_req, d_we, d_addr, d_wdata, d_width,
    output d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_instr, if_valid,
    output d_req, d_we, d_addr, d_wdata, d_width,
    input  d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_width,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between instruction fetch and data load/store.
// Only one access is outstanding. Data has priority, and a starvation counter bounds the fetch wait.
module mem_port_arbiter #(
  parameter int size       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  typedef struct packed {
    logic            we;
    logic [size-1:0] addr;
    logic [size-1:0] wdata;
    logic [2:0]      width;
  } mem_cmd_t;

  state_t          state;
  owner_t          owner;
  logic            kill;
  logic [SW-1:0]   starve_cnt;
  logic            req;
  mem_cmd_t        cmd;
  logic            if_valid, d_done;
  logic [size-1:0] if_instr, d_rdata;

  logic f_elig, d_elig, starve_full, fetch_win, fetch_flush;

  // A requester whose done is pulsing is still showing the request that just finished.
  assign f_elig      = bus.if_req & ~if_valid;
  assign d_elig      = bus.d_req & ~d_done;
  assign starve_full = (starve_cnt == SW'(STARVE_MAX));
  assign fetch_win   = f_elig & (~d_elig | starve_full);
  assign fetch_flush = bus.if_flush & (owner == OWN_FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_FETCH;
      kill       <= 1'b0;
      starve_cnt <= '0;
      req        <= 1'b0;
      cmd        <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      d_done     <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_win) begin
            cmd        <= '{we: 1'b0, addr: bus.if_addr, wdata: '0, width: 3'b010};
            owner      <= OWN_FETCH;
            starve_cnt <= '0;
            req        <= 1'b1;
            state      <= REQ;
          end else if (d_elig) begin
            cmd   <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, width: bus.d_width};
            owner <= OWN_DATA;
            if (!bus.if_req)
              starve_cnt <= '0;
            else if (!starve_full)
              starve_cnt <= starve_cnt + 1'b1;
            req   <= 1'b1;
            state <= REQ;
          end else if (!bus.if_req) begin
            starve_cnt <= '0;
          end
        end
        REQ: begin
          if (fetch_flush) kill <= 1'b1;
          if (bus.mem_gnt) begin
            req   <= 1'b0;
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
            if (owner == OWN_DATA) begin
              d_done  <= 1'b1;
              d_rdata <= cmd.we ? '0 : bus.mem_rdata;
            end else begin
              // A flush arriving with the response kills it just like an earlier one.
              if (!(kill || bus.if_flush)) begin
                if_valid <= 1'b1;
                if_instr <= bus.mem_rdata;
              end
              kill <= 1'b0;
            end
          end else if (fetch_flush) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = req;
  assign bus.mem_we    = cmd.we;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.mem_width = cmd.width;
  assign bus.if_valid  = if_valid;
  assign bus.if_instr  = if_instr;
  assign bus.d_done    = d_done;
  assign bus.d_rdata   = d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requesters and a random memory drive the arbiter.
// Every cycle is compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int SM = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.size(W)) bus ();
  mem_port_arbiter #(.size(W), .STARVE_MAX(SM)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus expected outputs.
  typedef struct {
    bit          live;
    bit          granted;
    bit          is_data;
    bit          killed;
    bit          we;
    logic [31:0] addr, wdata;
    logic [2:0]  width;
  } txn_t;

  txn_t        t;
  int          data_streak;
  bit          e_req, e_ifv, e_dd;
  logic [31:0] e_ins, e_drd;

  // Stimulus knobs (percent)
  int pf, pd, pg, pr, pfl;
  bit fix;

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic model_reset();
    t = '{default: '0};
    data_streak = 0;
    e_req = 0; e_ifv = 0; e_dd = 0; e_ins = '0; e_drd = '0;
  endtask

  task automatic model_step();
    bit f_ok, d_ok;
    f_ok  = bus.if_req && !e_ifv;
    d_ok  = bus.d_req && !e_dd;
    e_ifv = 0;
    e_dd  = 0;
    if (!t.live) begin
      if (f_ok && (!d_ok || data_streak >= SM)) begin
        t = '{live: 1, granted: 0, is_data: 0, killed: 0, we: 0,
              addr: bus.if_addr, wdata: '0, width: 3'b010};
        data_streak = 0;
        e_req = 1;
      end else if (d_ok) begin
        t = '{live: 1, granted: 0, is_data: 1, killed: 0, we: bus.d_we,
              addr: bus.d_addr, wdata: bus.d_wdata, width: bus.d_width};
        data_streak = bus.if_req ? ((data_streak < SM) ? data_streak + 1 : SM) : 0;
        e_req = 1;
      end else if (!bus.if_req) begin
        data_streak = 0;
      end
    end else if (!t.granted) begin
      if (!t.is_data && bus.if_flush) t.killed = 1;
      if (bus.mem_gnt) begin
        t.granted = 1;
        e_req = 0;
      end
    end else begin
      if (!t.is_data && bus.if_flush) t.killed = 1;
      if (bus.mem_rvalid) begin
        if (t.is_data) begin
          e_dd  = 1;
          e_drd = t.we ? 32'h0 : bus.mem_rdata;
        end else if (!t.killed) begin
          e_ifv = 1;
          e_ins = bus.mem_rdata;
        end
        t.live = 0;
        t.killed = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("mem_req",   32'(bus.mem_req),   32'(e_req));
    chk("mem_we",    32'(bus.mem_we),    32'(t.we));
    chk("mem_addr",  bus.mem_addr,       t.addr);
    chk("mem_wdata", bus.mem_wdata,      t.wdata);
    chk("mem_width", 32'(bus.mem_width), 32'(t.width));
    chk("if_valid",  32'(bus.if_valid),  32'(e_ifv));
    chk("if_instr",  bus.if_instr,       e_ins);
    chk("d_done",    32'(bus.d_done),    32'(e_dd));
    chk("d_rdata",   bus.d_rdata,        e_drd);
  endtask

  task automatic react();
    if (e_ifv || !bus.if_req) begin
      bus.if_req  = pct(pf);
      bus.if_addr = fix ? 32'h100 : ($urandom() & 32'hFFFF_FFFC);
    end
    if (e_dd || !bus.d_req) begin
      bus.d_req   = pct(pd);
      bus.d_we    = fix ? 1'b1 : 1'($urandom_range(1));
      bus.d_addr  = fix ? 32'h1000 : $urandom();
      bus.d_wdata = fix ? 32'hDEADBEEF : $urandom();
      bus.d_width = fix ? 3'b010 : 3'($urandom_range(7));
    end
    bus.mem_gnt    = pct(pg);
    bus.mem_rvalid = pct(pr);
    bus.mem_rdata  = fix ? 32'h00500093 : $urandom();
    bus.if_flush   = pct(pfl);
  endtask

  // Async reset mid-cycle: outputs must clear before the next edge.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 reset = 1'b1;
  endtask

  task automatic run(input int n, input int f, input int d, input int g, input int r,
                     input int fl, input bit fx, input int rst_at);
    pf = f; pd = d; pg = g; pr = r; pfl = fl; fix = fx;
    react();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
      check_all();
      if (i == rst_at) reset_pulse();
      react();
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_width = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    run(40,  100, 0,   100, 100, 0,  1, -1);
    run(40,  0,   100, 100, 100, 0,  1, -1);
    run(60,  100, 100, 100, 100, 0,  0, -1);
    run(120, 100, 0,   100, 50,  30, 0, -1);
    run(200, 100, 100, 60,  60,  25, 0, -1);
    run(600, 60,  60,  50,  50,  10, 0, 300);
    run(150, 100, 100, 30,  30,  5,  0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
